// File: rtl/mcm_pipe.sv
`default_nettype none
//============================================================================
// Module   : mcm_pipe
// Purpose  : Multi-lane, two-stage elastic shift-add multiplier of unsigned
//            samples by the 22 angular-interpolation filter coefficients.
//            Define MCM_PIPE_SAT_EN to clamp products to OUT_W instead of
//            wrapping them.
// Revision : 1.0 - initial release
//============================================================================
module mcm_pipe #(
    parameter int SAMPLE_W = 8,
    parameter int LANES    = 4,
    parameter int OUT_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*SAMPLE_W-1:0]   in_x,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*22*OUT_W-1:0]   out_y,
    output logic                        ovf
);

    localparam int c_iw    = SAMPLE_W + 6;
    localparam int c_ncoef = 22;

    // Fundamental slots: 0:x 1:3x 2:5x 3:7x 4:9x 5:11x 6:13x 7:15x
    function automatic logic signed [c_iw-1:0] coef_prod(
        input int                     k,
        input logic signed [c_iw-1:0] x,
        input logic signed [c_iw-1:0] f3,
        input logic signed [c_iw-1:0] f5,
        input logic signed [c_iw-1:0] f7,
        input logic signed [c_iw-1:0] f9,
        input logic signed [c_iw-1:0] f11,
        input logic signed [c_iw-1:0] f13,
        input logic signed [c_iw-1:0] f15
    );
        case (k)
            0:       coef_prod = -x;
            1:       coef_prod = -(x <<< 1);
            2:       coef_prod = -f3;
            3:       coef_prod = -(x <<< 2);
            4:       coef_prod = -f5;
            5:       coef_prod = -(f3 <<< 1);
            6:       coef_prod = x <<< 4;
            7:       coef_prod = f15;
            8:       coef_prod = f7 <<< 1;
            9:       coef_prod = f13;
            10:      coef_prod = f3 <<< 2;
            11:      coef_prod = f11;
            12:      coef_prod = f5 <<< 1;
            13:      coef_prod = f9;
            14:      coef_prod = x <<< 3;
            15:      coef_prod = f7;
            16:      coef_prod = f3 <<< 1;
            17:      coef_prod = f5;
            18:      coef_prod = x <<< 2;
            19:      coef_prod = f3;
            20:      coef_prod = x <<< 1;
            default: coef_prod = x;
        endcase
    endfunction

    logic                   r_s1_valid;
    logic                   r_s2_valid;
    logic                   r_ovf;
    logic [LANES*22*OUT_W-1:0] r_out_y;
    logic                   w_s1_adv;
    logic                   w_s2_adv;

    logic signed [c_iw-1:0] w_fund [LANES][8];
    logic signed [c_iw-1:0] r_fund [LANES][8];
    logic [LANES*22*OUT_W-1:0] w_red;
    logic [LANES*22-1:0]       w_ovf;

    assign w_s2_adv  = !r_s2_valid || out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign in_ready  = w_s1_adv;
    assign out_valid = r_s2_valid;
    assign out_y     = r_out_y;
    assign ovf       = r_ovf;

    // 11x and 13x reuse 3x so every fundamental is one add/subtract deep past 3x
    for (genvar l = 0; l < LANES; l++) begin : g_s1_lane
        logic signed [c_iw-1:0] w_x;
        assign w_x = $signed({6'b0, in_x[l*SAMPLE_W +: SAMPLE_W]});
        assign w_fund[l][0] = w_x;
        assign w_fund[l][1] = (w_x <<< 1) + w_x;
        assign w_fund[l][2] = (w_x <<< 2) + w_x;
        assign w_fund[l][3] = (w_x <<< 3) - w_x;
        assign w_fund[l][4] = (w_x <<< 3) + w_x;
        assign w_fund[l][5] = (w_fund[l][1] <<< 2) - w_x;
        assign w_fund[l][6] = (w_fund[l][1] <<< 2) + w_x;
        assign w_fund[l][7] = (w_x <<< 4) - w_x;
    end

    for (genvar l = 0; l < LANES; l++) begin : g_s2_lane
        for (genvar k = 0; k < c_ncoef; k++) begin : g_coef
            logic signed [c_iw-1:0] w_p;
            assign w_p = coef_prod(k, r_fund[l][0], r_fund[l][1], r_fund[l][2],
                                   r_fund[l][3], r_fund[l][4], r_fund[l][5],
                                   r_fund[l][6], r_fund[l][7]);
            if (OUT_W >= c_iw) begin : g_wide
                assign w_red[(l*c_ncoef+k)*OUT_W +: OUT_W] = OUT_W'(w_p);
                assign w_ovf[l*c_ncoef+k] = 1'b0;
            end else begin : g_narrow
                logic w_fit;
                // Fits when every bit above the OUT_W sign bit equals it
                assign w_fit = (w_p[c_iw-1:OUT_W-1] == {(c_iw-OUT_W+1){w_p[c_iw-1]}});
                assign w_ovf[l*c_ncoef+k] = !w_fit;
`ifdef MCM_PIPE_SAT_EN
                assign w_red[(l*c_ncoef+k)*OUT_W +: OUT_W] = w_fit ? w_p[OUT_W-1:0] :
                    (w_p[c_iw-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}});
`else
                assign w_red[(l*c_ncoef+k)*OUT_W +: OUT_W] = w_p[OUT_W-1:0];
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                for (int j = 0; j < 8; j++) begin
                    r_fund[l][j] <= '0;
                end
            end
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_fund <= w_fund;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_out_y    <= '0;
            r_ovf      <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_y <= w_red;
                if (|w_ovf) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
